// File: rtl/push_arbiter.sv
// Arbitrates five pulsed push requests into a single queue write port.
// Define PUSH_ARB_RR_EN for round-robin selection; fixed priority (bit0 first) otherwise.
module push_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req,
    input  logic       full,
    input  logic       ovf_clr,
    output logic       wr_en,
    output logic [5:0] wr_data,
    output logic [4:0] grant,
    output logic [4:0] pending,
    output logic [4:0] ovf
);

    typedef enum logic [1:0] {IDLE, ARB, PUSH} state_t;

    state_t     state, state_nxt;
    logic [4:0] grant_nxt;
    logic [4:0] pick;
    logic [4:0] clearing;
    logic [4:0] pending_nxt;
    logic [4:0] ovf_nxt;
    logic       push_done;
    logic       found;

    assign push_done   = (state == PUSH) && !full;
    assign clearing    = push_done ? grant : '0;
    // A same-edge request wins over the completing push's clear.
    assign pending_nxt = (pending & ~clearing) | req;
    assign ovf_nxt     = (ovf & ~{5{ovf_clr}}) | (req & pending & ~clearing);
    assign wr_en       = push_done;

`ifdef PUSH_ARB_RR_EN
    logic [2:0] last;
    logic [2:0] last_nxt;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < 5; off++) begin
            int unsigned idx;
            idx = (32'(last) + 32'd1 + off) % 32'd5;
            if (!found && pending[idx[2:0]]) begin
                pick[idx[2:0]] = 1'b1;
                found          = 1'b1;
            end
        end
    end

    always_comb begin
        last_nxt = last;
        if (push_done) begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (grant[i[2:0]]) last_nxt = i[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last <= 3'd4;
        else        last <= last_nxt;
    end
`else
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            if (!found && pending[i[2:0]]) begin
                pick[i[2:0]] = 1'b1;
                found        = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: if (|pending) state_nxt = ARB;
            ARB: begin
                grant_nxt = pick;
                state_nxt = (|pick) ? PUSH : IDLE;
            end
            PUSH: begin
                if (!full) begin
                    grant_nxt = '0;
                    state_nxt = (|pending_nxt) ? ARB : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_comb begin
        case (grant)
            5'b00001: wr_data = 6'd11;
            5'b00010: wr_data = 6'd22;
            5'b00100: wr_data = 6'd33;
            5'b01000: wr_data = 6'd44;
            5'b10000: wr_data = 6'd55;
            default:  wr_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            pending <= '0;
            ovf     <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            pending <= pending_nxt;
            ovf     <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_push_arbiter.sv
// Directed bench for push_arbiter; expectations follow the build's PUSH_ARB_RR_EN setting.
module tb_push_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] req = '0;
    logic       full = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       wr_en;
    logic [5:0] wr_data;
    logic [4:0] grant;
    logic [4:0] pending;
    logic [4:0] ovf;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    push_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .full    (full),
        .ovf_clr (ovf_clr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .grant   (grant),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        full = 1'b0;
        ovf_clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [5:0] exp_codes [8];
    int unsigned npush;
    int unsigned nrepulse;

    initial begin
        // Reset state
        #2;
        chk("rst_wr_en", 8'(wr_en), 8'd0);
        chk("rst_wr_data", 8'(wr_data), 8'd0);
        chk("rst_grant", 8'(grant), 8'd0);
        chk("rst_pending", 8'(pending), 8'd0);
        chk("rst_ovf", 8'(ovf), 8'd0);
        do_reset();

        // Single request latency; req sampled on first edge after release
        req = 5'b00001;
        step();
        req = '0;
        chk("lat_pending", 8'(pending), 8'd1);
        chk("lat_c1_wr_en", 8'(wr_en), 8'd0);
        step();
        chk("lat_c2_wr_en", 8'(wr_en), 8'd0);
        step();
        chk("lat_c3_wr_en", 8'(wr_en), 8'd1);
        chk("lat_c3_wr_data", 8'(wr_data), 8'd11);
        chk("lat_c3_grant", 8'(grant), 8'd1);
        step();
        chk("lat_after_pending", 8'(pending), 8'd0);
        chk("lat_after_wr_en", 8'(wr_en), 8'd0);
        chk("lat_after_ovf", 8'(ovf), 8'd0);
        chk("lat_after_wr_data", 8'(wr_data), 8'd0);

        // All five requests at once
        do_reset();
`ifdef PUSH_ARB_RR_EN
        nrepulse = 0;
        npush = 5;
        exp_codes = '{6'd11, 6'd22, 6'd33, 6'd44, 6'd55, 6'd0, 6'd0, 6'd0};
`else
        nrepulse = 3;
        npush = 8;
        exp_codes = '{6'd11, 6'd11, 6'd11, 6'd11, 6'd22, 6'd33, 6'd44, 6'd55};
`endif
        req = 5'b11111;
        step();
        req = '0;
        chk("all_pending", 8'(pending), 8'h1f);
        for (int unsigned j = 0; j < npush; j++) begin
            step();
            req = '0;
            chk("all_arb_wr_en", 8'(wr_en), 8'd0);
            chk("all_arb_pend4", 8'(pending[4]), 8'd1);
            step();
            chk("all_push_wr_en", 8'(wr_en), 8'd1);
            chk("all_push_code", 8'(wr_data), 8'(exp_codes[j]));
            if (j < nrepulse) req = 5'b00001;
        end
        step();
        req = '0;
        chk("all_done_pending", 8'(pending), 8'd0);
        chk("all_done_wr_en", 8'(wr_en), 8'd0);
        chk("all_done_ovf", 8'(ovf), 8'd0);

        // Stall on full with grant=00100
        do_reset();
        req = 5'b00100;
        step();
        req = '0;
        step();
        full = 1'b1;
        step();
        chk("stall_grant", 8'(grant), 8'h04);
        chk("stall_wr_en", 8'(wr_en), 8'd0);
        chk("stall_wr_data", 8'(wr_data), 8'd33);
        req = 5'b00100;
        step();
        req = '0;
        chk("stall_ovf_set", 8'(ovf), 8'h04);
        chk("stall_wr_data2", 8'(wr_data), 8'd33);
        req = 5'b00100;
        ovf_clr = 1'b1;
        step();
        req = '0;
        ovf_clr = 1'b0;
        chk("stall_ovf_clr_vs_set", 8'(ovf), 8'h04);
        chk("stall_wr_en3", 8'(wr_en), 8'd0);
        step();
        chk("stall_wr_data4", 8'(wr_data), 8'd33);
        chk("stall_grant4", 8'(grant), 8'h04);
        full = 1'b0;
        #1;
        chk("stall_release_wr_en", 8'(wr_en), 8'd1);
        step();
        chk("stall_after_wr_en", 8'(wr_en), 8'd0);
        chk("stall_after_pending", 8'(pending), 8'd0);
        chk("stall_after_ovf", 8'(ovf), 8'h04);
        step();
        chk("stall_idle_wr_en", 8'(wr_en), 8'd0);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 8'(ovf), 8'd0);

        // Same-edge re-request of the index being pushed
        do_reset();
        req = 5'b01000;
        step();
        req = '0;
        step();
        step();
        chk("rereq_code1", 8'(wr_data), 8'd44);
        chk("rereq_wr_en1", 8'(wr_en), 8'd1);
        req = 5'b01000;
        step();
        req = '0;
        chk("rereq_pending", 8'(pending), 8'h08);
        chk("rereq_ovf", 8'(ovf), 8'd0);
        step();
        chk("rereq_code2", 8'(wr_data), 8'd44);
        chk("rereq_wr_en2", 8'(wr_en), 8'd1);
        step();
        chk("rereq_pending_end", 8'(pending), 8'd0);

        // Reset asserted mid-push
        do_reset();
        req = 5'b00010;
        step();
        req = '0;
        step();
        step();
        chk("abort_pre_wr_en", 8'(wr_en), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_wr_en", 8'(wr_en), 8'd0);
        chk("abort_wr_data", 8'(wr_data), 8'd0);
        chk("abort_grant", 8'(grant), 8'd0);
        chk("abort_pending", 8'(pending), 8'd0);
        step();
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 10; k++) begin
            step();
            chk("abort_quiet_wr_en", 8'(wr_en), 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/push_arbiter.md
PUSH_ARBITER -- requirements
Module: push_arbiter

Interface
REQ-001 clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 req  input  5  request pulses; bit i requests a push of code 11*(i+1).
REQ-004 full  input  1  queue-full status from the RAM queue write port.
REQ-005 ovf_clr  input  1  synchronous clear of the ovf flags.
REQ-006 wr_en  output  1  queue write strobe; one accepted push per cycle asserted.
REQ-007 wr_data  output  6  code being pushed: 11, 22, 33, 44 or 55.
REQ-008 grant  output  5  one-hot registered index of the requester being served, or 0.
REQ-009 pending  output  5  latched, not-yet-pushed requests.
REQ-010 ovf  output  5  sticky flag: req[i] arrived while pending[i] was already set.

Function
REQ-011 The block SHALL set pending[i] on any rising edge where req[i]=1; set has priority over a same-edge clear of pending[i].
REQ-012 The FSM SHALL have exactly three states: IDLE, ARB, PUSH.
REQ-013 IDLE SHALL go to ARB when pending!=0 and stay otherwise; grant=0 in IDLE.
REQ-014 ARB SHALL load grant with exactly one pending bit, chosen by the policy in REQ-030/031, then go to PUSH.
REQ-015 In PUSH, wr_en SHALL equal !full combinationally; wr_data SHALL be 11*(k+1) for grant bit k; wr_data=0 whenever grant=0.
REQ-016 PUSH with full=1 SHALL hold state, grant and wr_data unchanged, with no timeout.
REQ-017 On a PUSH edge with full=0, the block SHALL clear pending[k] (subject to REQ-011), record k as last-served, and go to ARB if other pending bits remain, else IDLE.
REQ-018 Latency: req[i] high in cycle c with FSM idle and full=0 SHALL give wr_en=1 in cycle c+3.
REQ-019 Sustained throughput SHALL be one push per 2 cycles; wr_en SHALL never be high outside PUSH.
REQ-020 ovf[i] SHALL set when req[i]=1 and pending[i]=1 and pending[i] is not being cleared on that edge; the request is merged, not queued twice.
REQ-021 ovf_clr=1 SHALL clear all ovf bits, except bits being set on the same edge, which stay set.
REQ-022 A request for the granted index arriving during PUSH with full=1 SHALL count as an overflow per REQ-020.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, pending=0, grant=0, ovf=0 and last-served pointer=4.
REQ-024 wr_en SHALL be 0 and wr_data SHALL be 0 while rst_n=0.
REQ-025 Reset asserted mid-PUSH SHALL abort the push; no wr_en pulse SHALL follow reset release until a new req arrives.
REQ-026 The first edge after rst_n deasserts SHALL sample req normally.

Configuration
REQ-030 With PUSH_ARB_RR_EN defined, ARB SHALL select round-robin: search starts at (last-served+1) mod 5, ascending with wrap.
REQ-031 Without PUSH_ARB_RR_EN, ARB SHALL use fixed priority (bit0 highest, bit4 lowest), and the last-served pointer SHALL be unused.

Verification
REQ-040 Reset, then req=00001 for one cycle, full=0 -> wr_en=1, wr_data=11 in cycle c+3; pending=0 afterwards; ovf=0.
REQ-041 req=11111 for one cycle, full=0, RR enabled -> pushes of 11, 22, 33, 44, 55 on every second cycle; pending reaches 0.
REQ-042 Same as REQ-041 without PUSH_ARB_RR_EN, re-pulsing req[0] after each push -> every push is 11; pending[4] is never cleared while req[0] keeps re-asserting.
REQ-043 full=1 in PUSH for 4 cycles, grant=00100 -> wr_en=0 and wr_data=33 held; full=0 -> a single wr_en pulse; a req[2] during the stall sets ovf[2].
REQ-044 rst_n pulsed low in PUSH -> outputs go to 0 asynchronously; after release with req=0, no wr_en for 10 cycles.
REQ-045 req[3] on the same edge as its push completes -> pending[3] stays set, a second 44 is pushed, and ovf[3] stays 0.
